// File: rtl/store_buffer_drain_ctrl_pkg.sv
// Shared types for the D-cache store buffer drain path.
// Holds the store buffer entry layout, depth constant and drain FSM state encoding.
package store_buffer_drain_ctrl_pkg;

  localparam int DCACHE_ST_BUFFER_NUM_ENTRIES = 8;
  localparam int DCACHE_ST_BUFFER_ADDR_W      = 32;
  localparam int DCACHE_ST_BUFFER_DATA_W      = 32;
  localparam int DCACHE_ST_BUFFER_BE_W        = DCACHE_ST_BUFFER_DATA_W / 8;

  typedef struct packed {
    logic [DCACHE_ST_BUFFER_ADDR_W-1:0] addr;
    logic [DCACHE_ST_BUFFER_DATA_W-1:0] data;
    logic [DCACHE_ST_BUFFER_BE_W-1:0]   be;
  } store_buffer_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    REQ   = 2'd2,
    WAIT  = 2'd3
  } drain_state_t;

endpackage

// File: rtl/store_buffer_drain_ctrl_occupancy.sv
// Store buffer occupancy: one increment and two decrement sources per cycle.
// Bounds are assertion-guarded; the count never wraps in legal operation.
module sb_occupancy_counter #(
  parameter int NUM_ENTRIES = 8,
  parameter int OCC_WIDTH   = $clog2(NUM_ENTRIES + 1)
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_inc,
  input  logic                 i_dec_a,
  input  logic                 i_dec_b,
  output logic [OCC_WIDTH-1:0] o_occ
);

  localparam logic [OCC_WIDTH:0] L_MAX = (OCC_WIDTH + 1)'(NUM_ENTRIES);

  logic [OCC_WIDTH-1:0] r_occ;
  logic [OCC_WIDTH:0]   w_up;
  logic [OCC_WIDTH:0]   w_down;
  logic [OCC_WIDTH:0]   w_next;

  assign w_up   = {1'b0, r_occ} + {{OCC_WIDTH{1'b0}}, i_inc};
  assign w_down = {{OCC_WIDTH{1'b0}}, i_dec_a} + {{OCC_WIDTH{1'b0}}, i_dec_b};
  assign w_next = w_up - w_down;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) r_occ <= '0;
    else          r_occ <= w_next[OCC_WIDTH-1:0];
  end

  assign o_occ = r_occ;

  a_no_underflow: assert property (@(posedge i_clock) disable iff (!i_reset) w_up >= w_down);
  a_no_overflow:  assert property (@(posedge i_clock) disable iff (!i_reset) w_next <= L_MAX);

endmodule

// File: rtl/store_buffer_drain_ctrl.sv
// Decides when to pop the oldest store buffer entry and writes it into the D-cache.
// Drains opportunistically on pipeline idle, forcibly when full, and completely on flush.
//
// state | meaning
// IDLE  | no write in flight; waiting for a drain trigger with the pipeline free
// ISSUE | one-cycle pop of the oldest entry; payload captured
// REQ   | write request held valid until the cache accepts it
// WAIT  | request accepted; waiting for the write completion
module store_buffer_drain_ctrl
  import store_buffer_drain_ctrl_pkg::*;
#(
  parameter int NUM_ENTRIES    = DCACHE_ST_BUFFER_NUM_ENTRIES,
  parameter int IDLE_THRESHOLD = 4,
  parameter int OCC_WIDTH      = $clog2(NUM_ENTRIES + 1)
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_sb_push_valid,
  input  logic                 i_sb_search_remove,
  output logic                 o_sb_get_oldest,
  input  store_buffer_t        i_sb_oldest_info,
  input  logic                 i_pipe_busy,
  output logic                 o_stall_push,
  input  logic                 i_flush_req,
  output logic                 o_flush_done,
  output logic                 o_wr_req_valid,
  output store_buffer_t        o_wr_req_info,
  input  logic                 i_wr_req_ready,
  input  logic                 i_wr_rsp_valid,
  output logic [OCC_WIDTH-1:0] o_sb_occupancy
);

  localparam int                   IDLE_W     = $clog2(IDLE_THRESHOLD + 1);
  localparam logic [IDLE_W-1:0]    L_IDLE_MAX = IDLE_W'(IDLE_THRESHOLD);
  localparam logic [OCC_WIDTH-1:0] L_FULL     = OCC_WIDTH'(NUM_ENTRIES);

  drain_state_t         r_state;
  drain_state_t         w_next_state;
  logic [IDLE_W-1:0]    r_idle_cnt;
  logic                 r_flush_pending;
  logic                 r_flush_done;
  store_buffer_t        r_wr_req_info;
  logic [OCC_WIDTH-1:0] w_occ;
  logic                 w_full;
  logic                 w_trigger;
  logic                 w_flush_fire;
  logic                 w_get_oldest;
  logic                 w_wr_req_valid;

  sb_occupancy_counter #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .OCC_WIDTH   (OCC_WIDTH)
  ) u_occ (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_inc   (i_sb_push_valid),
    .i_dec_a (w_get_oldest),
    .i_dec_b (i_sb_search_remove),
    .o_occ   (w_occ)
  );

  assign w_full    = (w_occ == L_FULL);
  assign w_trigger = (w_occ != '0) && ((r_idle_cnt == L_IDLE_MAX) || w_full || r_flush_pending);

  // A same-cycle flush_req counts as pending so an empty-buffer flush completes one cycle later.
  assign w_flush_fire = (r_flush_pending || i_flush_req) && (w_occ == '0) &&
                        !i_sb_push_valid && (r_state == IDLE);

  always_comb begin
    w_next_state   = r_state;
    w_get_oldest   = 1'b0;
    w_wr_req_valid = 1'b0;
    case (r_state)
      IDLE:  if (w_trigger && !i_pipe_busy) w_next_state = ISSUE;
      ISSUE: begin
        w_get_oldest = 1'b1;
        w_next_state = REQ;
      end
      REQ: begin
        w_wr_req_valid = 1'b1;
        if (i_wr_req_ready) w_next_state = i_wr_rsp_valid ? IDLE : WAIT;
      end
      WAIT:  if (i_wr_rsp_valid) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state         <= IDLE;
      r_idle_cnt      <= '0;
      r_flush_pending <= 1'b0;
      r_flush_done    <= 1'b0;
      r_wr_req_info   <= '0;
    end else begin
      r_state <= w_next_state;
      if (i_pipe_busy)                    r_idle_cnt <= '0;
      else if (r_idle_cnt != L_IDLE_MAX)  r_idle_cnt <= r_idle_cnt + 1'b1;
      r_flush_pending <= w_flush_fire ? 1'b0 : (r_flush_pending || i_flush_req);
      r_flush_done    <= w_flush_fire;
      if (r_state == ISSUE) r_wr_req_info <= i_sb_oldest_info;
    end
  end

  assign o_sb_get_oldest = w_get_oldest;
  assign o_wr_req_valid  = w_wr_req_valid;
  assign o_wr_req_info   = r_wr_req_info;
  assign o_flush_done    = r_flush_done;
  assign o_stall_push    = w_full && (r_state != ISSUE);
  assign o_sb_occupancy  = w_occ;

endmodule

// File: doc/store_buffer_drain_ctrl.md
Name: store_buffer_drain_ctrl

Overview:
- Sequences retirement of D-cache store buffer entries into the D-cache data array.
- Tracks store buffer occupancy and decides when to pop the oldest entry: opportunistically when the cache pipeline is idle, forcibly when the buffer is full, and exhaustively on a flush request.
- Drives a valid/ready write request toward the cache and back-pressures new pushes when no slot is available.

Parameters:
- NUM_ENTRIES, `DCACHE_ST_BUFFER_NUM_ENTRIES (8): store buffer depth.
- IDLE_THRESHOLD, 4: consecutive idle pipeline cycles before an opportunistic drain.
- OCC_WIDTH, $clog2(NUM_ENTRIES+1): occupancy counter width.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- sb_push_valid  in  1  store buffer push occurring this cycle.
- sb_search_remove  in  1  search hit invalidated one entry this cycle.
- sb_get_oldest  out  1  pop request to store buffer; single-cycle pulse.
- sb_oldest_info  in  store_buffer_t  oldest entry, valid in the cycle sb_get_oldest is high.
- pipe_busy  in  1  cache pipeline holds a load/store this cycle.
- stall_push  out  1  pipeline must not push a store this cycle.
- flush_req  in  1  drain-all request, one-cycle pulse.
- flush_done  out  1  one-cycle pulse when a flush has completed.
- wr_req_valid  out  1  write request to D-cache.
- wr_req_info  out  store_buffer_t  write payload.
- wr_req_ready  in  1  D-cache accepts the request.
- wr_rsp_valid  in  1  D-cache write completed.
- sb_occupancy  out  OCC_WIDTH  current entry count.

Behaviour:
- Reset: asynchronous, active-low. State IDLE. occ=0, idle_cnt=0, flush_pending=0. All outputs 0; wr_req_info=0.
  - Reset mid-transaction abandons the request. The integration level resets store buffer and cache together.
- Occupancy, computed each cycle:
  - occ_next = occ + sb_push_valid − sb_get_oldest − sb_search_remove.
  - A simultaneous push and pop leaves occ unchanged.
  - Assertions: occ never underflows and never exceeds NUM_ENTRIES.
- idle_cnt: increments while pipe_busy=0, saturates at IDLE_THRESHOLD, clears to 0 on any pipe_busy=1.
- trigger = (occ>0) & (idle_cnt==IDLE_THRESHOLD | occ==NUM_ENTRIES | flush_pending).
- stall_push = (occ==NUM_ENTRIES) & !(state==ISSUE).
  - Combinational from registered state.
  - Holding off pushes drains pipe_busy, so a forced drain eventually issues.
- FSM states and transitions:
  - IDLE: go to ISSUE when trigger & !pipe_busy.
    - sb_get_oldest is never asserted while pipe_busy=1. This prevents a same-cycle search removal from colliding with the pop.
  - ISSUE (1 cycle): sb_get_oldest=1. Capture sb_oldest_info into wr_req_info. Go to REQ.
  - REQ: wr_req_valid=1 with wr_req_info stable until wr_req_ready=1.
    - If wr_req_ready=1 is seen on entry, the request completes in that same cycle.
    - After the handshake, go to WAIT.
  - WAIT: on wr_rsp_valid, return to IDLE.
    - A wr_rsp_valid arriving in the handshake cycle is accepted directly; the FSM goes from REQ to IDLE.
- Latency: minimum trigger-to-handshake is 2 cycles (IDLE→ISSUE→REQ with ready high). Only one write is outstanding at any time.
- Flush:
  - flush_req sets flush_pending. A flush_req while already pending is absorbed.
  - When flush_pending & occ==0 & state==IDLE: clear flush_pending and pulse flush_done the next cycle.
  - flush_req with an empty buffer gives flush_done 1 cycle later.
- Pushes may continue during a flush. flush_done waits until the buffer is truly empty.
- Widths: idle_cnt is $clog2(IDLE_THRESHOLD+1) bits. All counters saturate or are assertion-guarded; none wraps.

Decomposition:
- store_buffer_t, the `DCACHE_ST_BUFFER_* constants, and a new drain_state_t enum (IDLE, ISSUE, REQ, WAIT) live in the shared soc package/header.
- One natural sub-module: sb_occupancy_counter (up/down counter with bound assertions). Everything else stays in this module.

Test Plan:
- Opportunistic drain: 1 push, then pipe_busy=0 for 4 cycles → sb_get_oldest pulses on cycle 5. wr_req_valid on cycle 6 carrying the pushed payload. occ goes 1→0.
- Busy pipeline suppresses drain: occ=3, pipe_busy toggles every 3 cycles → no sb_get_oldest ever; occ stays 3.
- Full buffer: 8 back-to-back pushes → stall_push=1 with occ=8. Drop pipe_busy → single pop, stall_push=0 in the ISSUE cycle, occ=7.
- Back-pressure: hold wr_req_ready=0 for 5 cycles → wr_req_valid and wr_req_info stable; no second sb_get_oldest until wr_rsp_valid.
- Flush: occ=3, flush_req, cache ready=1 and rsp 1 cycle after accept → 3 pops, then a single flush_done pulse with occ=0. flush_req at occ=0 → flush_done next cycle.
- Simultaneous events and reset: push and pop in the same cycle → occ unchanged. Assert reset low in REQ → all outputs 0 immediately, state IDLE.
